// File: rtl/fb_mem_lsu.sv
// MEM-stage load/store unit: formats stores, aligns/extends loads, and runs the
// data-memory req/ready handshake with timeout while stalling the pipeline.
`timescale 1ns/1ps
module fb_mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_rs2_data,
  input  logic [31:0] mem_inst,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        lsu_stall,
  output logic [31:0] wb_load_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        to_flag;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;

  logic        acc, legal, aligned, start, fault, idle_live;
  logic [2:0]  f3;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic        unused_inst;

  assign unused_inst = ^{mem_inst[31:15], mem_inst[11:0]};
  assign f3  = mem_inst[14:12];
  assign acc = mem_mem_read | mem_mem_write;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    aligned = 1'b0;
    case (f3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << mem_alu_res[1:0];
        wdata_c = {4{mem_rs2_data[7:0]}};
        aligned = 1'b1;
      end
      2'b01: begin
        be_c    = mem_alu_res[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_rs2_data[15:0]}};
        aligned = ~mem_alu_res[0];
      end
      2'b10: begin
        be_c    = 4'b1111;
        wdata_c = mem_rs2_data;
        aligned = (mem_alu_res[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // A simultaneous read and write is treated as a read.
  assign legal = mem_mem_read ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (f3 inside {3'b000, 3'b001, 3'b010});

  // Gated by rst_n so the combinational stall/error also vanish the moment reset asserts.
  assign idle_live = (state == S_IDLE) & rst_n;
  assign start     = idle_live & acc & legal & aligned;
  assign fault     = idle_live & acc & ~(legal & aligned);

  always_comb begin
    ld_h = lat_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (lat_addr[1:0])
      2'b00:   ld_b = dm_rdata[7:0];
      2'b01:   ld_b = dm_rdata[15:8];
      2'b10:   ld_b = dm_rdata[23:16];
      default: ld_b = dm_rdata[31:24];
    endcase
    case (lat_f3)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = dm_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      to_flag      <= 1'b0;
      lat_we       <= 1'b0;
      lat_f3       <= 3'b000;
      lat_addr     <= 32'h0;
      lat_be       <= 4'b0000;
      lat_wdata    <= 32'h0;
      wb_load_data <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_we    <= mem_mem_write & ~mem_mem_read;
            lat_f3    <= f3;
            lat_addr  <= mem_alu_res;
            lat_be    <= be_c;
            lat_wdata <= wdata_c;
            cnt       <= 8'd0;
            to_flag   <= 1'b0;
            state     <= S_BUSY;
          end else if (fault) begin
            wb_load_data <= 32'h0;
          end
        end
        S_BUSY: begin
          if (dm_ready) begin
            if (!lat_we) wb_load_data <= ld_ext;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            wb_load_data <= 32'h0;
            to_flag      <= 1'b1;
            state        <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          to_flag <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dm_req       = (state == S_BUSY);
  assign dm_we        = dm_req & lat_we;
  assign dm_be        = dm_req ? lat_be : 4'b0000;
  assign dm_wdata     = dm_req ? lat_wdata : 32'h0;
  assign dm_addr      = {lat_addr[31:2], 2'b00};
  assign lsu_stall    = start | dm_req;
  assign misalign_err = fault;
  assign bus_err      = (state == S_DONE) & to_flag;

endmodule

// File: tb/tb_fb_mem_lsu.sv
// Scoreboarded random bench for fb_mem_lsu: a driver pushes predicted bus/result
// behaviour into a queue; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fb_mem_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_mem_read = 1'b0, mem_mem_write = 1'b0;
  logic [31:0] mem_alu_res = '0, mem_rs2_data = '0, mem_inst = '0;
  logic        dm_req, dm_we, dm_ready = 1'b0;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = '0;
  logic [3:0]  dm_be;
  logic        lsu_stall, misalign_err, bus_err;
  logic [31:0] wb_load_data;

  fb_mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_alu_res(mem_alu_res), .mem_rs2_data(mem_rs2_data), .mem_inst(mem_inst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .lsu_stall(lsu_stall), .wb_load_data(wb_load_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    bit          we;
    bit          to;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
    int          stall_cyc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] model_wb = '0;
  bit          mon_en = 1'b0;
  int          resp_delay = 0;
  logic [31:0] resp_rdata = '0;
  int          wcnt = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: ready after resp_delay request cycles; junk while idle.
  always @(posedge clk) begin
    #1;
    if (dm_req) begin
      dm_ready = (wcnt == resp_delay);
      dm_rdata = resp_rdata;
      wcnt++;
    end else begin
      wcnt     = 0;
      dm_ready = 1'($urandom_range(0, 1));
      dm_rdata = $urandom;
    end
  end

  function automatic logic [31:0] extend(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (addr % 4))) & 32'hFF;
    h = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  // Monitor
  int   stall_cnt = 0;
  bit   prev_stall = 0, req_seen = 0, pend_wb = 0;
  logic [31:0] pend_wb_val;

  task automatic pop(output exp_t e, output bit ok);
    ok = (q.size() != 0);
    if (ok) e = q.pop_front();
    else begin
      n_cmp++; n_fail++;
      $display("FAIL unexpected_response: got DUT event, expected none queued (t=%0t)", $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ok, done_now;
    if (mon_en) begin
      done_now = prev_stall && !lsu_stall;
      if (pend_wb) begin
        check("wb_after_fault", wb_load_data, pend_wb_val);
        pend_wb = 0;
      end
      if (!dm_req) check("bus_idle_zero", {dm_we, dm_be, dm_wdata}, 0);
      if (!done_now) check("bus_err_quiet", bus_err, 0);
      if (lsu_stall) begin
        stall_cnt++;
        if (dm_req && !req_seen) begin
          req_seen = 1;
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL req_unexpected: got dm_req=1, expected no access");
          end else begin
            check("dm_addr", dm_addr, {q[0].addr[31:2], 2'b00});
            check("dm_we", dm_we, q[0].we);
            check("dm_be", dm_be, q[0].be);
            if (q[0].we) check("dm_wdata", dm_wdata, q[0].wdata);
          end
        end
      end
      if (done_now) begin
        pop(e, ok);
        if (ok) begin
          check("done_not_fault", e.fault, 0);
          check("stall_cycles", stall_cnt, e.stall_cyc);
          check("bus_err", bus_err, e.to);
          check("wb_load_data", wb_load_data, e.wb);
          check("req_low_done", dm_req, 0);
        end
        stall_cnt = 0;
        req_seen  = 0;
      end
      if (misalign_err) begin
        pop(e, ok);
        if (ok) begin
          check("misalign_expected", e.fault, 1);
          check("fault_no_stall", {lsu_stall, dm_req}, 0);
          pend_wb     = 1;
          pend_wb_val = e.wb;
        end
      end
      prev_stall = lsu_stall;
    end
  end

  // Driver: called and returns at posedge+1.
  task automatic drive_idle();
    mem_mem_read  = 1'b0;
    mem_mem_write = 1'b0;
    mem_alu_res   = $urandom;
    mem_rs2_data  = $urandom;
    mem_inst      = $urandom;
  endtask

  task automatic issue(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr,
                       logic [31:0] rs2, int delay, logic [31:0] rdata);
    exp_t        e;
    logic [31:0] inst;
    int          sz, k;
    bit          legal, aligned;
    sz      = int'(f3[1:0]);
    legal   = rd ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    aligned = (sz == 0) || (sz == 1 && addr % 2 == 0) || (sz == 2 && addr % 4 == 0);
    e.fault = !(legal && aligned);
    e.we    = wr && !rd;
    e.addr  = addr;
    e.be    = (sz == 0) ? 4'(1 << (addr % 4)) : (sz == 1) ? ((addr % 4 >= 2) ? 4'hC : 4'h3) : 4'hF;
    e.wdata = (sz == 0) ? (rs2 & 32'hFF) * 32'h01010101 :
              (sz == 1) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
    e.to    = !e.fault && (delay >= TO);
    e.stall_cyc = e.to ? 1 + TO : 2 + delay;
    if (e.fault || e.to) model_wb = 32'h0;
    else if (!e.we)      model_wb = extend(f3, addr, rdata);
    e.wb = model_wb;
    q.push_back(e);

    resp_delay = delay;
    resp_rdata = rdata;
    inst = $urandom;
    inst[14:12] = f3;
    mem_mem_read = rd; mem_mem_write = wr;
    mem_alu_res = addr; mem_rs2_data = rs2; mem_inst = inst;
    if (e.fault) begin
      @(posedge clk); #1;
    end else begin
      k = 0;
      do begin @(negedge clk); k++; end while (lsu_stall && k < 400);
      if (k >= 400) check("access_timeout", k, 0);
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3;
    int         kind;
    logic [31:0] addr;
    #3;
    check("rst_outputs", {dm_req, dm_we, lsu_stall, misalign_err, bus_err}, 0);
    check("rst_wb", wb_load_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(1, 0, 3'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF);       // LW, 2 wait cycles
    issue(0, 1, 3'd0, 32'h203, 32'h12345678, 0, 32'h0);       // SB lane 3
    issue(1, 0, 3'd1, 32'h302, 32'h0, 1, 32'h80010000);       // LH
    issue(1, 0, 3'd5, 32'h302, 32'h0, 0, 32'h80010000);       // LHU
    issue(1, 0, 3'd0, 32'h301, 32'h0, 0, 32'h00008000);       // LB
    issue(1, 0, 3'd2, 32'h101, 32'h0, 0, 32'h0);              // misaligned LW
    issue(1, 0, 3'd2, 32'h104, 32'h0, 0, 32'h11112222);
    issue(1, 0, 3'd3, 32'h100, 32'h0, 0, 32'h0);              // illegal load funct3
    issue(0, 1, 3'd4, 32'h100, 32'h0, 0, 32'h0);              // illegal store funct3
    issue(1, 0, 3'd2, 32'h108, 32'h0, 255, 32'h0);            // bus timeout
    issue(1, 0, 3'd2, 32'h10C, 32'h0, TO - 1, 32'hCAFEF00D);  // ready on last allowed cycle
    issue(0, 1, 3'd1, 32'h206, 32'hA5A5BEEF, 1, 32'h0);       // SH upper half
    issue(1, 1, 3'd2, 32'h400, 32'h77777777, 0, 32'h13579BDF); // read wins
    issue(0, 1, 3'd2, 32'h40C, 32'hFEEDFACE, 255, 32'h0);     // store timeout

    repeat (150) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      kind = $urandom_range(0, 4);
      f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
           : (kind == 1) ? 3'($urandom_range(0, 2))
           : 3'(3'($urandom_range(0, 4)) + ((3'($urandom_range(0, 4)) >= 3) ? 3'd1 : 3'd0));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      issue(kind != 1, kind == 1 || kind == 2, f3, addr, $urandom,
            ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, TO + 1), $urandom);
    end

    // Reset asserted in the second BUSY cycle of a load that never completes.
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    resp_delay = 255;
    mem_mem_read = 1'b1; mem_mem_write = 1'b0;
    mem_alu_res = 32'h500; mem_inst = 32'h00002003;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy2_req", dm_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_req", dm_req, 0);
    check("rst_mid_stall", lsu_stall, 0);
    check("rst_mid_wb", wb_load_data, 0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete();
    model_wb = 32'h0;
    stall_cnt = 0; prev_stall = 0; req_seen = 0; pend_wb = 0;
    mon_en = 1'b1;
    issue(0, 1, 3'd2, 32'h600, 32'h0BADF00D, 1, 32'h0);
    issue(1, 0, 3'd4, 32'h603, 32'h0, 0, 32'h9A000000);

    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
